// File: rtl/uart_tx.sv
// UART serial transmitter: valid/ready input FIFO feeding an LSB-first frame serialiser
// (start, data, optional parity, stop bits) clocked bit-by-bit on a shared baud_tick.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push, pop, fifo_empty;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 par;

  assign tx_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && tx_ready;
  assign par        = (^shift_q) ^ 1'(PARITY_ODD);

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE);

  // FIFO storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Each state names the bit currently on the line; transitions happen only on baud_tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shift_q[bit_idx_q + IDX_W'(1)];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
        PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            // Chain straight into the next frame when one is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (default, even parity, odd parity, two stop bits)
// share clock, reset and baud_tick; each has its own valid so tests address one at a time.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic [3:0] valid;
  logic [3:0] ready_w, tx_w, busy_w, done_w;

  int n_chk = 0;
  int n_err = 0;
  int dcnt [4] = '{0, 0, 0, 0};
  logic [7:0] fb [8];
  int fn;
  int d0, d1, d2, d3;

  always #5 clk = ~clk;

  uart_tx u0 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid[0]),
              .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .baud_tick(baud_tick),
              .tx_data(tx_data), .tx_valid(valid[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]),
              .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .baud_tick(baud_tick),
              .tx_data(tx_data), .tx_valid(valid[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]),
              .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
              .tx_valid(valid[3]), .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]),
              .tx_done(done_w[3]));

  // Count tx_done cycles per instance, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done_w[i]) dcnt[i] <= dcnt[i] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    repeat (2) @(negedge clk);
    baud_tick = 1'b1;
    @(posedge clk);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic push(input logic [3:0] mask, input logic [7:0] d);
    @(negedge clk);
    valid   = mask;
    tx_data = d;
    @(posedge clk);
    #1;
    valid = 4'b0000;
  endtask

  // Expected default-config line level after tick t of fn back-to-back frames in fb.
  function automatic logic exp_bit(input int t);
    int f, p;
    f = (t - 1) / 10;
    p = (t - 1) % 10;
    if (f >= fn) return 1'b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return fb[f][p-1];
  endfunction

  task automatic run_frames(input int t_from, input int t_to);
    for (int t = t_from; t <= t_to; t++) begin
      tick();
      check("frame_tx", 32'(tx_w[0]), 32'(exp_bit(t)));
      check("frame_busy", 32'(busy_w[0]), 32'(t <= 10 * fn));
      check("frame_done", 32'(done_w[0]), 32'(t > 1 && (t - 1) % 10 == 0 && (t - 1) / 10 <= fn));
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       e1, e2, e3;
    int p, f;
    rst = 1'b1; baud_tick = 1'b0; tx_data = 8'h00; valid = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_w[0]), 32'd1);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_ready", 32'(ready_w), 32'hF);
    rst = 1'b0;

    // Tick with empty FIFO does nothing
    tick();
    check("idle_tick_tx", 32'(tx_w[0]), 32'd1);
    check("idle_tick_busy", 32'(busy_w[0]), 32'd0);

    // Test 1: single 0xA5 frame
    push(4'b0001, 8'hA5);
    check("t1_no_tick_tx", 32'(tx_w[0]), 32'd1);
    fb[0] = 8'hA5; fn = 1; d0 = dcnt[0];
    run_frames(1, 12);
    @(posedge clk); #1;
    check("t1_done_width", 32'(done_w[0]), 32'd0);
    check("t1_done_count", 32'(dcnt[0] - d0), 32'd1);

    // Test 2: parity, 0x07 -> even parity 1, odd parity 0
    push(4'b0110, 8'h07);
    d = 8'h07; d1 = dcnt[1]; d2 = dcnt[2];
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1) begin e1 = 1'b0; e2 = 1'b0; end
      else if (t <= 9) begin e1 = d[t-2]; e2 = d[t-2]; end
      else if (t == 10) begin e1 = 1'b1; e2 = 1'b0; end
      else begin e1 = 1'b1; e2 = 1'b1; end
      check("t2_even_tx", 32'(tx_w[1]), 32'(e1));
      check("t2_odd_tx", 32'(tx_w[2]), 32'(e2));
      check("t2_busy", 32'(busy_w[2:1]), (t <= 11) ? 32'd3 : 32'd0);
      check("t2_done", 32'(done_w[2:1]), (t == 12) ? 32'd3 : 32'd0);
    end
    check("t2_done_count", 32'((dcnt[1] - d1) + (dcnt[2] - d2)), 32'd2);

    // Test 3: fill FIFO without ticks, fifth push ignored, back-to-back frames
    for (int i = 1; i <= 5; i++) begin
      push(4'b0001, 8'(i));
      check("t3_ready", 32'(ready_w[0]), (i < 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) fb[i] = 8'(i + 1);
    fn = 4; d0 = dcnt[0];
    run_frames(1, 43);
    check("t3_done_count", 32'(dcnt[0] - d0), 32'd4);

    // Test 4: push held across a pop while full; pointers wrap
    for (int i = 0; i < 4; i++) push(4'b0001, 8'(8'h11 * (i + 1)));
    check("t4_full", 32'(ready_w[0]), 32'd0);
    d0 = dcnt[0];
    repeat (2) @(negedge clk);
    valid = 4'b0001; tx_data = 8'h66; baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
    check("t4_ready_after_pop", 32'(ready_w[0]), 32'd1);
    check("t4_launch_tx", 32'(tx_w[0]), 32'd0);
    @(posedge clk); #1;
    valid = 4'b0000;
    check("t4_push_accepted", 32'(ready_w[0]), 32'd0);
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h66; fn = 5;
    run_frames(2, 53);
    check("t4_done_count", 32'(dcnt[0] - d0), 32'd5);

    // Test 5: two stop bits, two 0x00 frames
    push(4'b1000, 8'h00);
    push(4'b1000, 8'h00);
    d3 = dcnt[3];
    for (int t = 1; t <= 24; t++) begin
      tick();
      f = (t - 1) / 11;
      p = (t - 1) % 11;
      e3 = (f >= 2) || (p >= 9);
      check("t5_tx", 32'(tx_w[3]), 32'(e3));
      check("t5_done", 32'(done_w[3]), 32'(t == 12 || t == 23));
      check("t5_busy", 32'(busy_w[3]), 32'(t <= 22));
    end
    check("t5_done_count", 32'(dcnt[3] - d3), 32'd2);

    // Test 6: reset during data bit 3 with a byte still queued
    push(4'b0001, 8'hA5);
    push(4'b0001, 8'h5A);
    fb[0] = 8'hA5; fn = 2; d0 = dcnt[0];
    run_frames(1, 5);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(tx_w[0]), 32'd1);
    check("t6_rst_busy", 32'(busy_w[0]), 32'd0);
    check("t6_rst_ready", 32'(ready_w[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t6_no_done", 32'(dcnt[0] - d0), 32'd0);
    fn = 0;
    run_frames(1, 3);
    push(4'b0001, 8'h3C);
    fb[0] = 8'h3C; fn = 1; d0 = dcnt[0];
    run_frames(1, 12);
    check("t6_done_count", 32'(dcnt[0] - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
